// File: rtl/data_memory_pkg.sv
// Shared constants and types for the data-memory responder: I/O register
// offsets, default I/O window base and the address-decoder region enum.
package data_memory_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] IO_BASE_DEFAULT = 32'h0000_1000;

  // Byte offsets inside the 16-byte I/O window
  localparam logic [3:0] OFS_OUT    = 4'h0;
  localparam logic [3:0] OFS_TIMER  = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_NONE
  } region_t;

endpackage

// File: rtl/data_memory_if.sv
// Load/store port between the single-cycle processor (master) and the
// data-memory responder (slave).
interface data_memory_if;
  import data_memory_pkg::*;

  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              mem_write;
  logic [DATA_W-1:0] read_data;

  modport master (
    output address,
    output write_data,
    output mem_write,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data,
    input  mem_write,
    output read_data
  );

endinterface

// File: rtl/mem_io_regs.sv
// Memory-mapped I/O registers: OUT, free-running TIMER, and the sticky err
// flag exposed through STATUS. Only built when DATA_MEMORY_IO_EN is defined.
module mem_io_regs
  import data_memory_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        ofs,
  input  logic [DATA_W-1:0] wdata,
  input  logic              err_set,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] io_out,
  output logic              err
);

  logic [DATA_W-1:0] timer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_out <= '0;
      timer  <= '0;
      err    <= 1'b0;
    end else begin
      // A TIMER store overrides the increment of the same cycle
      if (wr_en && ofs == OFS_TIMER) timer <= wdata;
      else                           timer <= timer + 1'b1;

      if (wr_en && ofs == OFS_OUT) io_out <= wdata;

      // A new bad access outranks a STATUS clear in the same cycle
      if (err_set)                                         err <= 1'b1;
      else if (wr_en && ofs == OFS_STATUS && wdata[0]) err <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_OUT:    rdata = io_out;
      OFS_TIMER:  rdata = timer;
      OFS_STATUS: rdata = {{(DATA_W-1){1'b0}}, err};
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Data-memory responder: word RAM plus optional I/O window (DATA_MEMORY_IO_EN).
// Zero-latency combinational loads, stores commit on the next rising edge.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int                DEPTH   = 64,
  parameter logic [DATA_W-1:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_if.slave      bus,
  output logic [DATA_W-1:0] io_out,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

`ifdef DATA_MEMORY_IO_EN
  localparam bit IO_PRESENT = 1'b1;
`else
  localparam bit IO_PRESENT = 1'b0;
`endif

  logic [DATA_W-1:0] ram [DEPTH];
  logic [AW-1:0]     widx;
  region_t           region;
  logic              io_hit;
  logic              aligned;
  logic              ram_wr;
  logic              bad_wr;
  logic [DATA_W-1:0] io_rdata;
  logic [DATA_W-1:0] rd;

  assign widx    = bus.address[AW+1:2];
  assign io_hit  = (bus.address[DATA_W-1:4] == IO_BASE[DATA_W-1:4]);
  assign aligned = (bus.address[1:0] == 2'b00);

  // Without the I/O window its range decodes as unmapped
  always_comb begin
    region = REG_NONE;
    if (bus.address[DATA_W-1:AW+2] == '0) region = REG_RAM;
    else if (IO_PRESENT && io_hit)        region = REG_IO;
  end

  assign ram_wr = bus.mem_write && aligned && (region == REG_RAM);
  assign bad_wr = bus.mem_write && (!aligned || region == REG_NONE);

  // RAM is deliberately outside reset so a reset pulse preserves its contents
  always_ff @(posedge clk) begin
    if (ram_wr) ram[widx] <= bus.write_data;
  end

`ifdef DATA_MEMORY_IO_EN
  logic io_wr;

  assign io_wr = bus.mem_write && aligned && (region == REG_IO);

  mem_io_regs u_io_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (io_wr),
    .ofs     ({bus.address[3:2], 2'b00}),
    .wdata   (bus.write_data),
    .err_set (bad_wr),
    .rdata   (io_rdata),
    .io_out  (io_out),
    .err     (err)
  );
`else
  assign io_rdata = '0;
  assign io_out   = '0;

  // With no STATUS register, only reset clears err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        err <= 1'b0;
    else if (bad_wr) err <= 1'b1;
  end
`endif

  always_comb begin
    rd = '0;
    case (region)
      REG_RAM: rd = ram[widx];
      REG_IO:  rd = io_rdata;
      default: rd = '0;
    endcase
  end

  assign bus.read_data = rd;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed table, hand sequences for I/O and reset
// corners, then random traffic against a transaction-level reference model.
module tb_data_memory;

  localparam int          DEPTH     = 64;
  localparam logic [31:0] IO_BASE   = 32'h0000_1000;
  localparam logic [31:0] RAM_BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] io_out;
  logic        err;

  data_memory_if bus ();

  data_memory #(.DEPTH(DEPTH), .IO_BASE(IO_BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .io_out (io_out),
    .err    (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [31:0] ram_m [DEPTH];
  bit          wr_m  [DEPTH];
  logic [31:0] io_m;
  logic        err_m;
  logic [31:0] tmr_base;
  logic [31:0] tmr_cyc;
  logic [31:0] cycle = '0;

  always @(posedge clk) if (rst) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic bit in_io(input logic [31:0] a);
`ifdef DATA_MEMORY_IO_EN
    return (a >= IO_BASE) && (a < IO_BASE + 32'd16);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
    int idx;
    v = '0;
    if (a < RAM_BYTES) begin
      idx = int'(a >> 2);
      v = ram_m[idx];
      return wr_m[idx];
    end
    if (in_io(a)) begin
      case (int'((a - IO_BASE) >> 2))
        0:       v = io_m;
        1:       v = tmr_base + (cycle - tmr_cyc);
        2:       v = {31'b0, err_m};
        default: v = '0;
      endcase
    end
    return 1'b1;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] wd);
    if (a % 4 != 0) begin
      err_m = 1'b1;
      return;
    end
    if (a < RAM_BYTES) begin
      ram_m[int'(a >> 2)] = wd;
      wr_m[int'(a >> 2)]  = 1'b1;
      return;
    end
    if (in_io(a)) begin
      case (int'((a - IO_BASE) >> 2))
        0: io_m = wd;
        1: begin tmr_base = wd; tmr_cyc = cycle; end
        2: if (wd[0]) err_m = 1'b0;
        default: ;
      endcase
      return;
    end
    err_m = 1'b1;
  endfunction

  function automatic void m_reset();
    io_m     = '0;
    err_m    = 1'b0;
    tmr_base = '0;
    tmr_cyc  = cycle;
  endfunction

  // One bus cycle: drive, compare pre-edge outputs with the model, then commit
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      output logic [31:0] rd_seen, output logic err_seen);
    logic [31:0] exp;
    @(negedge clk);
    bus.address    = a;
    bus.write_data = wd;
    bus.mem_write  = we;
    #1;
    rd_seen  = bus.read_data;
    err_seen = err;
    if (m_read(a, exp)) chk($sformatf("model_rd@%h", a), bus.read_data, exp);
    chk("model_err", {31'b0, err}, {31'b0, err_m});
    chk("model_io_out", io_out, io_m);
    @(posedge clk);
    #1;
    if (we) m_write(a, wd);
    bus.mem_write = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.mem_write = 1'b0;
    #1 rst = 1'b0;
    m_reset();
    #1;
    chk("rst_io_out", io_out, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    #1 rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          pre_rst;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic        e;
    logic [31:0] a;

    bus.address    = '0;
    bus.write_data = '0;
    bus.mem_write  = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr_m[i] = 1'b0;
    io_m = '0; err_m = 1'b0; tmr_base = '0; tmr_cyc = '0;

    #1;
    chk("reset_io_out", io_out, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_reset();

    // Reset then read the I/O window (unmapped reads 0 in the minimal build too)
    step(IO_BASE,          32'h0, 1'b0, rd, e); chk("io_out_rd_after_reset", rd, 32'h0);
    step(IO_BASE + 32'h8,  32'h0, 1'b0, rd, e); chk("status_rd_after_reset", rd, 32'h0);

    vecs.push_back('{32'h10,  32'h1111_1111, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0});
    vecs.push_back('{32'h10,  32'h0000_000A, 1'b1, 1'b1, 32'h1111_1111,  1'b0, 1'b0});
    vecs.push_back('{32'h10,  32'h0,         1'b0, 1'b1, 32'h0000_000A,  1'b0, 1'b0});
    vecs.push_back('{32'hFC,  32'hF0F0_F0F0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0});
    vecs.push_back('{32'hFC,  32'h0,         1'b0, 1'b1, 32'hF0F0_F0F0,  1'b0, 1'b0});
    vecs.push_back('{32'h11,  32'h0000_1234, 1'b1, 1'b1, 32'h0000_000A,  1'b0, 1'b0});
    vecs.push_back('{32'h10,  32'h0,         1'b0, 1'b1, 32'h0000_000A,  1'b1, 1'b0});
    vecs.push_back('{32'h13,  32'h0,         1'b0, 1'b1, 32'h0000_000A,  1'b1, 1'b0});
    vecs.push_back('{32'h10,  32'h0,         1'b0, 1'b1, 32'h0000_000A,  1'b0, 1'b1});
    vecs.push_back('{32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0,          1'b0, 1'b0});
    vecs.push_back('{32'h100, 32'h0,         1'b0, 1'b1, 32'h0,          1'b1, 1'b0});
    vecs.push_back('{32'hFC,  32'h0,         1'b0, 1'b1, 32'hF0F0_F0F0,  1'b1, 1'b0});

    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) pulse_reset();
      step(vecs[i].addr, vecs[i].wd, vecs[i].we, rd, e);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
    end

`ifdef DATA_MEMORY_IO_EN
    // STATUS clear
    step(IO_BASE + 32'h6, 32'h9, 1'b1, rd, e);
    step(IO_BASE + 32'h8, 32'h1, 1'b1, rd, e); chk("status_before_clear", rd, 32'h1);
    step(IO_BASE + 32'h8, 32'h0, 1'b0, rd, e); chk("status_after_clear", rd, 32'h0);
    chk("err_after_clear", {31'b0, e}, 32'h0);

    // TIMER load and wrap
    step(IO_BASE + 32'h4, 32'hFFFF_FFFE, 1'b1, rd, e);
    step(IO_BASE + 32'h4, 32'h0, 1'b0, rd, e); chk("timer_load", rd, 32'hFFFF_FFFE);
    step(IO_BASE + 32'h4, 32'h0, 1'b0, rd, e); chk("timer_inc",  rd, 32'hFFFF_FFFF);
    step(IO_BASE + 32'h4, 32'h0, 1'b0, rd, e); chk("timer_wrap", rd, 32'h0000_0000);

    // OUT, reserved slot, misaligned I/O store
    step(IO_BASE,          32'h55, 1'b1, rd, e);
    step(IO_BASE + 32'hC,  32'h77, 1'b1, rd, e); chk("io_out_55", io_out, 32'h55);
    step(IO_BASE + 32'hC,  32'h0,  1'b0, rd, e); chk("reserved_rd", rd, 32'h0);
    chk("reserved_no_err", {31'b0, e}, 32'h0);
    step(IO_BASE + 32'h1,  32'h99, 1'b1, rd, e);
    step(IO_BASE,          32'h0,  1'b0, rd, e); chk("out_after_misaligned", rd, 32'h55);
    chk("err_misaligned_io", {31'b0, e}, 32'h1);
`else
    // Without the I/O window the range is unmapped and STATUS cannot clear err
    step(IO_BASE + 32'h8, 32'h1, 1'b1, rd, e); chk("noio_status_rd", rd, 32'h0);
    step(IO_BASE + 32'h4, 32'h5, 1'b1, rd, e); chk("noio_err_sticky", {31'b0, e}, 32'h1);
    step(IO_BASE + 32'h4, 32'h0, 1'b0, rd, e); chk("noio_timer_rd", rd, 32'h0);
    step(IO_BASE,         32'h55, 1'b1, rd, e); chk("noio_io_out", io_out, 32'h0);
`endif

    // Reset between edges: I/O state cleared at once, RAM retained
    pulse_reset();
    step(32'h10, 32'h0, 1'b0, rd, e); chk("ram_after_reset", rd, 32'h0000_000A);
    chk("io_out_after_reset", io_out, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0, 1:    a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        2:       a = 32'($urandom_range(0, DEPTH * 4 - 1));
        3, 4:    a = IO_BASE + 32'($urandom_range(0, 15));
        5:       a = RAM_BYTES + 32'($urandom_range(0, 64));
        default: a = $urandom;
      endcase
      if (n % 97 == 96) pulse_reset();
      step(a, $urandom, 1'($urandom_range(0, 1)), rd, e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Data-memory responder for the single-cycle processor's load/store port. It consumes the processor's `alu_result`, `write_data` and `mem_write` outputs and returns `read_data`, closing the memory side of that interface. It holds a word-organised RAM and a small memory-mapped I/O window with an output register, a free-running timer and a sticky error flag. Sits beside the processor in the top level, opposite the instruction memory.

## Interface
- `DEPTH`, 64: RAM size in 32-bit words; power of two, 4..4096.
- `IO_BASE`, 32'h0000_1000: byte base address of the I/O window; 16-byte aligned, above the RAM region.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `address`  input  32  byte address; driven from processor `alu_result`.
- `write_data`  input  32  store data; driven from processor `write_data`.
- `mem_write`  input  1  store strobe; driven from processor `mem_write`.
- `read_data`  output  32  load data to the processor; combinational.
- `io_out`  output  32  contents of the OUT register.
- `err`  output  1  sticky bad-access flag.

## Operation
- RAM region: byte addresses 0 to DEPTH*4-1. Word index is `address[log2(DEPTH)+1:2]`.
- I/O window: IO_BASE to IO_BASE+15, with these word offsets:
  - +0x0 OUT: read/write.
  - +0x4 TIMER: read/write; a write loads `write_data`.
  - +0x8 STATUS: read returns `{31'b0, err}`; a write with `write_data[0]=1` clears `err`.
  - +0xC reserved: reads 0, writes ignored, not an error.
- Read path (combinational, every cycle):
  - RAM hit returns the RAM word.
  - I/O hit returns the register value.
  - Anything else returns 32'h0.
  - `address[1:0]` is ignored on reads.
- Write path, taken only when `mem_write=1`:
  - Aligned write (`address[1:0]==0`) to RAM or to a writable I/O register commits at the next edge.
  - Misaligned write, or a write outside both regions, is dropped and sets `err`.
- Reads never set `err`.
- TIMER increments by 1 every cycle, wrapping 32'hFFFF_FFFF to 0.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values (asynchronous, immediate):
  - `io_out`=0, TIMER=0, `err`=0.
  - `read_data` follows the read path using the reset register values; a RAM read is undefined if that word has not been written.
- Load latency is 0 cycles: `read_data` settles in the same cycle `address` is applied. This is required by the single-cycle datapath.
- Store latency is 1 edge: data is visible on `read_data` from the cycle after the edge where `mem_write=1`.
- Read-during-write to the same word returns the old value until the edge.
- TIMER write and increment in the same cycle: the write wins, so TIMER equals `write_data` after the edge and increments from there.
- `err` set and STATUS clear in the same cycle: set wins, `err` stays 1.
- Reset asserted mid-store: the store is lost for I/O registers; RAM contents are unaffected.
- No back-pressure. The responder always accepts, and the processor never stalls.

## Configuration
- `DATA_MEMORY_IO_EN`:
  - Defined: I/O window present as described.
  - Undefined: no I/O window. `io_out` is tied to 0, and TIMER and STATUS do not exist. The IO_BASE range becomes out-of-range: reads return 0, and writes set `err`. `err` can then only be cleared by reset.

## Structure
- Package `data_memory_pkg`:
  - Register offsets `OFS_OUT`, `OFS_TIMER`, `OFS_STATUS`.
  - Default `IO_BASE`.
  - Enum `region_t` = {REG_RAM, REG_IO, REG_NONE} used by the address decoder.
- One sub-module, `mem_io_regs`, holding OUT, TIMER and the `err` logic with its read mux. It is instantiated only under `DATA_MEMORY_IO_EN`.
- RAM array and the decoder stay in `data_memory`.

## Test plan
- Reset then read: release `rst`, then read IO_BASE+0x0 and +0x8 -> `read_data`=0 for both; `io_out`=0; `err`=0.
- RAM store/load: write 32'h0000_000A to 0x10, then read 0x10 -> 32'h0000_000A on the next cycle. During the write cycle itself, the read returns the old value.
- Boundary word: with DEPTH=64, write 32'hF0F0_F0F0 to 0xFC -> reads back correctly. Write to 0x100 -> dropped, `err`=1, and a read of 0x100 returns 0.
- Misaligned store: write 32'h1234 to 0x11 -> `err`=1 and word 0x10 is unchanged. Then write 1 to IO_BASE+0x8 -> `err`=0 after the edge.
- Timer: write 32'hFFFF_FFFE to IO_BASE+0x4, then read on the following cycles -> FFFF_FFFE, FFFF_FFFF, 0000_0000 (wrap).
- OUT and reset mid-run: write 32'h55 to IO_BASE -> `io_out`=32'h55. Assert `rst` between edges -> `io_out`=0 immediately, while RAM word 0x10 retains its value.
